// File: rtl/conv_sched_pkg.sv
// Shared types and geometry for the conv tile scheduler: FSM states, word tags,
// control/status bit positions.
package conv_sched_pkg;

    localparam int unsigned TILE_NUM     = 30;
    localparam int unsigned TILE_WORDS   = 16;
    localparam int unsigned WGT_WORDS    = 9;
    localparam int unsigned OUT_PER_TILE = 4;
    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned FP_W         = 16;
    localparam int unsigned CNT_W        = 5;
    localparam int unsigned TILE_W       = 5;
    localparam int unsigned RES_W        = 7;

    localparam logic [ADDR_W-1:0] WGT_BASE = 12'hFEF;

    localparam int unsigned START_BIT = 0;
    localparam int unsigned ABORT_BIT = 1;

    localparam int unsigned ST_BUSY_BIT = 0;
    localparam int unsigned ST_DONE_BIT = 1;
    localparam int unsigned ST_SERR_BIT = 2;
    localparam int unsigned ST_ABRT_BIT = 3;
    localparam int unsigned ST_TILE_LSB = 8;
    localparam int unsigned ST_RES_LSB  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_T  = 3'd2,
        WAIT_PE = 3'd3,
        FIN     = 3'd4
    } sched_state_e;

    // Kind of word travelling to the PE: weight vs ifmap, and last word of a tile
    typedef struct packed {
        logic wgt;
        logic last;
    } word_tag_t;

endpackage

// File: rtl/sched_skid_buf.sv
// One-entry skid register holding a word and its tag while the PE stalls.
module sched_skid_buf
    import conv_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    input  word_tag_t         tag_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o,
    output word_tag_t         tag_o
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;
    word_tag_t         tag_q, tag_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        tag_d  = tag_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
            tag_d  = tag_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign tag_o  = tag_q;

endmodule

// File: rtl/conv_tile_sched.sv
// Streams weights then 30 ifmap tiles from SRAM into the conv PE and collects results.
// Optional cycle counter on perf_cycles when SCHED_PERF_CNT_EN is defined.
module conv_tile_sched
    import conv_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_wr,
    input  logic [31:0]       ctrl_wdata,
    output logic [31:0]       status,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic              pe_wgt_valid,
    output logic              pe_ifm_valid,
    output logic [DATA_W-1:0] pe_data,
    input  logic              pe_ready,
    output logic              pe_tile_last,
    input  logic              pe_out_valid,
    input  logic [FP_W-1:0]   pe_out_data,
    output logic [31:0]       ofmap_out,
    output logic              dout_valid,
    output logic              done,
    output logic              busy,
    output logic [31:0]       perf_cycles
);

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  iss_q, iss_d, wcnt_q, wcnt_d, tres_q, tres_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [RES_W-1:0]  rcnt_q, rcnt_d;
    logic              done_q, done_d, serr_q, serr_d, abrt_q, abrt_d;
    logic              infl_q, infl_d, dout_q, dout_d;
    word_tag_t         infl_tag_q, infl_tag_d;
    logic [FP_W-1:0]   ofmap_q, ofmap_d;

    logic              start_c, abort_c, flush_c, consume_c, valid_c;
    logic              skid_full_c;
    logic [DATA_W-1:0] skid_data_c;
    word_tag_t         skid_tag_c, cur_tag_c;
    logic              unused_c;

    assign unused_c = ^ctrl_wdata[31:2];
    assign start_c  = ctrl_wr & ctrl_wdata[START_BIT] & ~ctrl_wdata[ABORT_BIT];
    assign abort_c  = ctrl_wr & ctrl_wdata[ABORT_BIT];
    assign flush_c  = abort_c & (state_q != IDLE);

    // Issue only with a free skid slot; at most one word is ever in flight.
    assign sram_rd_en = pe_ready & ~skid_full_c & ~abort_c &
                        (((state_q == LOAD_W) && (iss_q < CNT_W'(WGT_WORDS))) ||
                         ((state_q == LOAD_T) && (iss_q < CNT_W'(TILE_WORDS))));
    assign sram_rd_addr = addr_q;

    assign valid_c      = skid_full_c | infl_q;
    assign cur_tag_c    = skid_full_c ? skid_tag_c : infl_tag_q;
    assign pe_data      = skid_full_c ? skid_data_c : (infl_q ? sram_rd_data : '0);
    assign pe_wgt_valid = valid_c & cur_tag_c.wgt;
    assign pe_ifm_valid = valid_c & ~cur_tag_c.wgt;
    assign pe_tile_last = pe_ifm_valid & cur_tag_c.last;
    assign consume_c    = valid_c & pe_ready;

    sched_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_c),
        .load_i  (infl_q & ~pe_ready),
        .pop_i   (skid_full_c & pe_ready),
        .data_i  (sram_rd_data),
        .tag_i   (infl_tag_q),
        .full_o  (skid_full_c),
        .data_o  (skid_data_c),
        .tag_o   (skid_tag_c)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        iss_d      = iss_q;
        wcnt_d     = wcnt_q;
        tres_d     = tres_q;
        tile_d     = tile_q;
        rcnt_d     = rcnt_q;
        done_d     = done_q;
        serr_d     = serr_q;
        abrt_d     = abrt_q;
        infl_d     = sram_rd_en;
        infl_tag_d = infl_tag_q;
        dout_d     = pe_out_valid;
        ofmap_d    = pe_out_valid ? pe_out_data : ofmap_q;

        // Results are forwarded and counted in every state
        if (pe_out_valid && (rcnt_q != {RES_W{1'b1}})) rcnt_d = rcnt_q + RES_W'(1);
        if (sram_rd_en) begin
            addr_d          = addr_q + ADDR_W'(1);
            iss_d           = iss_q + CNT_W'(1);
            infl_tag_d.wgt  = (state_q == LOAD_W);
            infl_tag_d.last = (state_q == LOAD_T) && (iss_q == CNT_W'(TILE_WORDS - 1));
        end
        if (consume_c) wcnt_d = wcnt_q + CNT_W'(1);

        case (state_q)
            IDLE: if (start_c) begin
                state_d = LOAD_W;
                addr_d  = WGT_BASE;
                iss_d   = '0;
                wcnt_d  = '0;
                tres_d  = '0;
                tile_d  = '0;
                rcnt_d  = '0;
                done_d  = 1'b0;
                serr_d  = 1'b0;
                abrt_d  = 1'b0;
            end
            LOAD_W: if (consume_c && (wcnt_q == CNT_W'(WGT_WORDS - 1))) begin
                state_d = LOAD_T;
                addr_d  = '0;
                iss_d   = '0;
                wcnt_d  = '0;
            end
            LOAD_T: if (consume_c && (wcnt_q == CNT_W'(TILE_WORDS - 1))) begin
                state_d = WAIT_PE;
                tres_d  = '0;
            end
            WAIT_PE: if (pe_out_valid) begin
                if (tres_q == CNT_W'(OUT_PER_TILE - 1)) begin
                    tres_d = '0;
                    if (tile_q == TILE_W'(TILE_NUM - 1)) begin
                        state_d = FIN;
                    end else begin
                        state_d = LOAD_T;
                        tile_d  = tile_q + TILE_W'(1);
                        iss_d   = '0;
                        wcnt_d  = '0;
                    end
                end else begin
                    tres_d = tres_q + CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            if (abort_c) begin
                state_d = IDLE;
                abrt_d  = 1'b1;
                done_d  = 1'b0;
                infl_d  = 1'b0;
            end else if (start_c) begin
                serr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            iss_q      <= '0;
            wcnt_q     <= '0;
            tres_q     <= '0;
            tile_q     <= '0;
            rcnt_q     <= '0;
            done_q     <= 1'b0;
            serr_q     <= 1'b0;
            abrt_q     <= 1'b0;
            infl_q     <= 1'b0;
            infl_tag_q <= '0;
            dout_q     <= 1'b0;
            ofmap_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            iss_q      <= iss_d;
            wcnt_q     <= wcnt_d;
            tres_q     <= tres_d;
            tile_q     <= tile_d;
            rcnt_q     <= rcnt_d;
            done_q     <= done_d;
            serr_q     <= serr_d;
            abrt_q     <= abrt_d;
            infl_q     <= infl_d;
            infl_tag_q <= infl_tag_d;
            dout_q     <= dout_d;
            ofmap_q    <= ofmap_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign dout_valid = dout_q;
    assign ofmap_out  = {16'h0, ofmap_q};

    always_comb begin
        status                            = '0;
        status[ST_BUSY_BIT]               = busy;
        status[ST_DONE_BIT]               = done_q;
        status[ST_SERR_BIT]               = serr_q;
        status[ST_ABRT_BIT]               = abrt_q;
        status[ST_TILE_LSB +: TILE_W]     = tile_q;
        status[ST_RES_LSB +: RES_W]       = rcnt_q;
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state_q == IDLE) && start_c) begin
            perf_q <= '0;
        end else if (state_q != IDLE) begin
            perf_q <= perf_q + 32'(1);
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: doc/conv_tile_sched.md
Name: conv_tile_sched

Overview:
Sequencer between the ICB register slave and the FP16 3x3 conv datapath inside acc_top.
- On a start write to the control register it streams the 9 packed weight words from the accelerator SRAM into the PE.
- It then streams 30 tiles of 16 packed ifmap words.
- It collects 4 FP16 results per tile and raises done after 120 results.
- It exports busy/done/progress status for ICB reads.

Parameters:
TILE_NUM, 30, number of ifmap tiles per run
TILE_WORDS, 16, 32-bit SRAM words per tile (two FP16 channels packed {ch2,ch1})
WGT_WORDS, 9, 32-bit weight words (packed {w2,w1})
OUT_PER_TILE, 4, FP16 results expected per tile
ADDR_W, 12, SRAM word-address width
WGT_BASE, 12'hFEF, SRAM word address of weight word 0 (ifmap tile t word k at t*16+k)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ctrl_wr  in  1  one-cycle pulse: ICB write to control register
ctrl_wdata  in  32  bit0 start, bit1 abort
status  out  32  bit0 busy, bit1 done, bit2 start_err, bit3 aborted, [12:8] tile index, [22:16] result count
sram_rd_en  out  1  SRAM read strobe
sram_rd_addr  out  ADDR_W  SRAM word address
sram_rd_data  in  32  read data, valid exactly 1 cycle after sram_rd_en
pe_wgt_valid  out  1  weight word valid to PE
pe_ifm_valid  out  1  ifmap word valid to PE
pe_data  out  32  word to PE (weight or ifmap)
pe_ready  in  1  PE accepts word this cycle when high
pe_tile_last  out  1  with pe_ifm_valid: word 15 of tile
pe_out_valid  in  1  PE result strobe
pe_out_data  in  16  FP16 result
ofmap_out  out  32  {16'h0, registered result}
dout_valid  out  1  one-cycle pulse, ofmap_out valid
done  out  1  run complete, held until next accepted start
busy  out  1  FSM not IDLE
perf_cycles  out  32  run cycle count (see Optional Feature)

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0, skid register empty.
- FSM states:
  - IDLE: start=1 → LOAD_W; clear done and aborted.
  - LOAD_W: 9 reads at WGT_BASE..WGT_BASE+8. Last weight accepted → LOAD_T (tile 0).
  - LOAD_T: 16 reads at t*16..t*16+15. Word 15 accepted → WAIT_PE.
  - WAIT_PE: counts pe_out_valid. The 4th result → LOAD_T (t+1), or FIN if t==TILE_NUM-1.
  - FIN: one cycle; sets done, → IDLE.
- Read/handshake:
  - Issue a read only when pe_ready=1 and the skid register is empty.
  - Returned data drives pe_*_valid with pe_data the cycle after issue.
  - If pe_ready is low in that cycle, the word goes to the 1-entry skid register and is re-presented until accepted; no reads issue while the skid is full.
  - A word is consumed when valid && pe_ready.
  - Address counters advance on issue; word counters advance on consume.
- Results:
  - pe_out_valid in cycle N → dout_valid=1 and ofmap_out updated in N+1.
  - pe_out_valid outside WAIT_PE is still forwarded and counted.
  - Result count saturates at 127.
- Start while busy: ignored; sets start_err (sticky, cleared by the next accepted start).
- Abort: bit1 in any non-IDLE state → IDLE next cycle.
  - Clears skid and valids, sets aborted, done stays 0.
  - Abort wins over start in the same write.
- Reset mid-run returns everything to reset values immediately.
- Tile index and result count in status reflect live counters. Result count is cleared on accepted start.

Optional Feature:
SCHED_PERF_CNT_EN.
- Defined: perf_cycles clears on accepted start, increments every cycle while busy, and holds after done/abort.
- Undefined: perf_cycles tied to 0 and no counter logic.

Decomposition:
- Package conv_sched_pkg:
  - FSM state enum (IDLE, LOAD_W, LOAD_T, WAIT_PE, FIN).
  - Status bit-position constants.
  - Control bit constants (START_BIT=0, ABORT_BIT=1).
  - Default geometry localparams.
- Sub-module sched_skid_buf: 1-entry 32-bit skid register holding data and its weight/ifmap/last tag.

Test Plan:
- Full run, pe_ready=1, PE model returns 4 results 5 cycles after each tile's last word → reads are 0xFEF..0xFF7, then 0x000..0x1DF; 120 dout_valid pulses with pe_out_data mirrored into ofmap_out[15:0]; done=1, status=32'h0078_1D02.
- pe_ready toggled 1/0 every other cycle during LOAD_T → no word lost or duplicated; PE receives tile words in address order with pe_tile_last exactly on word 15.
- Start write while busy (tile 3) → start_err=1, run continues unchanged; next start after done clears start_err and done.
- Abort write at tile 10 word 7 → busy=0 next cycle, aborted=1, done=0, no further sram_rd_en; a new start restarts at weight address 0xFEF.
- Reset asserted mid-LOAD_T → all outputs 0 in the same cycle; after release, FSM is IDLE and done=0.
- With SCHED_PERF_CNT_EN and a no-stall run → perf_cycles equals the busy-cycle count measured by the bench; without the macro it reads 0.
